// File: rtl/mem_responder.sv
// Word-access responder: serves 16-bit little-endian loads/stores from a byte-wide array in two byte beats.
// Optional store write-protection of the low address region is enabled by defining MEMR_WPROT_EN.
module mem_responder #(
  parameter int          ADDR_WIDTH  = 14,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [15:0] PROTECT_TOP = 16'h00FF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BYTE0 = 3'd1,
    ST_BYTE1 = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam int          DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [16:0] MAX_ADDR  = 17'(DEPTH - 2);
  localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
`ifdef MEMR_WPROT_EN
  localparam logic        WPROT_EN  = 1'b1;
`else
  localparam logic        WPROT_EN  = 1'b0;
`endif

  state_t                  state_q, state_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             wdata_q, wdata_d;
  logic [3:0]              wait_q, wait_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [15:0]             rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [7:0]              mem_q [DEPTH];

  logic                    accept_s;
  logic                    range_ok_s;
  logic                    prot_hit_s;
  logic                    legal_s;
  logic                    mem_we_s;
  logic [ADDR_WIDTH-1:0]   addr_hi_s;

  // The top byte cannot start a word, so the last legal address is DEPTH-2; no wrap-around.
  assign accept_s   = req_valid && req_ready_q;
  assign range_ok_s = ({1'b0, req_addr} <= MAX_ADDR);
  assign prot_hit_s = WPROT_EN && req_write && (req_addr <= PROTECT_TOP);
  assign legal_s    = range_ok_s && !prot_hit_s;
  assign addr_hi_s  = addr_q + ADDR_WIDTH'(1);

  // Next-state, datapath and memory write-enable logic.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          write_d     = req_write;
          addr_d      = req_addr[ADDR_WIDTH-1:0];
          wdata_d     = req_wdata;
          rsp_rdata_d = 16'h0000;
          req_ready_d = 1'b0;
          if (legal_s) begin
            state_d = ST_BYTE0;
          end else begin
            state_d   = ST_RESP;
            rsp_err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BYTE0: begin
        if (!write_q) begin
          rsp_rdata_d[7:0] = mem_q[addr_q];
        end else begin
          rsp_rdata_d = rsp_rdata_q;
        end
        state_d = ST_BYTE1;
      end
      ST_BYTE1: begin
        // Both store bytes commit on this single edge so a store is never torn.
        if (!write_q) begin
          rsp_rdata_d[15:8] = mem_q[addr_hi_s];
        end else begin
          mem_we_s = 1'b1;
        end
        if (WAIT_CYCLES > 0) begin
          state_d = ST_WAIT;
          wait_d  = 4'd0;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = ST_RESP;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_RESP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  // Control and response registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 16'h0000;
      wait_q      <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte array; intentionally not reset.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_q[addr_q]    <= wdata_q[7:0];
      mem_q[addr_hi_s] <= wdata_q[15:8];
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
